spi_master_slave: RTL and testbench

SPI_MASTER_SLAVE -- requirements
Module: spi_master_slave

---
 rtl/spi_master_slave.sv | 202 ++++++++++++++++++++
 tb/tb_spi_master_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_slave.sv
// SPI mode-0 master and slave joined on an internal bus that is exported for observation.
// Defining SPI_LSB_FIRST_EN makes both ends shift LSB first; by default frames are MSB first.
module spi_master_slave #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       start_transfer,
  output logic       transfer_done,
  output logic [7:0] rx_data,
  input  logic [7:0] slave_tx_data,
  output logic [7:0] slave_rx_data,
  output logic       data_received,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  output logic       miso
);

  typedef enum logic [1:0] {IDLE, START, TRANSFER, DONE} m_state_t;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} s_state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

`ifdef SPI_LSB_FIRST_EN
  function automatic logic [7:0] shift_in(input logic [7:0] r, input logic b);
    return {b, r[7:1]};
  endfunction
  function automatic logic [7:0] shift_out(input logic [7:0] r);
    return {1'b0, r[7:1]};
  endfunction
  function automatic logic out_bit(input logic [7:0] r);
    return r[0];
  endfunction
`else
  function automatic logic [7:0] shift_in(input logic [7:0] r, input logic b);
    return {r[6:0], b};
  endfunction
  function automatic logic [7:0] shift_out(input logic [7:0] r);
    return {r[6:0], 1'b0};
  endfunction
  function automatic logic out_bit(input logic [7:0] r);
    return r[7];
  endfunction
`endif

  // ---------------- master ----------------
  m_state_t   m_state_q, m_state_d;
  logic [7:0] div_cnt;
  logic [3:0] toggle_cnt;
  logic [7:0] m_tx_shift;
  logic [7:0] m_rx_shift;
  logic       tick;
  logic       last_toggle;

  always_comb begin
    tick        = (div_cnt == DIV_LAST);
    last_toggle = tick && (toggle_cnt == 4'd15);
    m_state_d   = m_state_q;
    case (m_state_q)
      IDLE:     if (start_transfer) m_state_d = START;
      START:    if (tick) m_state_d = TRANSFER;
      TRANSFER: if (last_toggle) m_state_d = DONE;
      DONE:     m_state_d = IDLE;
      default:  m_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      m_state_q     <= IDLE;
      div_cnt       <= '0;
      toggle_cnt    <= '0;
      m_tx_shift    <= '0;
      m_rx_shift    <= '0;
      rx_data       <= '0;
      transfer_done <= 1'b0;
      sclk          <= 1'b0;
      ss_n          <= 1'b1;
      mosi          <= 1'b0;
    end else begin
      m_state_q     <= m_state_d;
      transfer_done <= 1'b0;
      case (m_state_q)
        IDLE: begin
          if (start_transfer) begin
            m_tx_shift <= tx_data;
            m_rx_shift <= '0;
            mosi       <= out_bit(tx_data);
            ss_n       <= 1'b0;
            div_cnt    <= '0;
            toggle_cnt <= '0;
          end
        end
        START: div_cnt <= tick ? '0 : div_cnt + 8'd1;
        TRANSFER: begin
          if (tick) begin
            div_cnt    <= '0;
            sclk       <= ~sclk;
            toggle_cnt <= toggle_cnt + 4'd1;
            if (!sclk) begin
              m_rx_shift <= shift_in(m_rx_shift, miso);
            end else if (!last_toggle) begin
              m_tx_shift <= shift_out(m_tx_shift);
              mosi       <= out_bit(shift_out(m_tx_shift));
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          ss_n          <= 1'b1;
          sclk          <= 1'b0;
          mosi          <= 1'b0;
          rx_data       <= m_rx_shift;
          transfer_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- slave ----------------
  // Edges are seen one cycle late via delayed copies; the master's half-period
  // of at least two cycles leaves miso settled before the next rising sclk.
  s_state_t   s_state_q, s_state_d;
  logic       sclk_d;
  logic       ss_n_d;
  logic [2:0] bit_cnt;
  logic [7:0] s_tx_shift;
  logic [7:0] s_rx_shift;
  logic       miso_bit;
  logic       ss_fall;
  logic       sclk_rise;
  logic       sclk_fall;

  assign miso = miso_bit & ~ss_n;

  always_comb begin
    ss_fall   = !ss_n && ss_n_d;
    sclk_rise = sclk && !sclk_d;
    sclk_fall = !sclk && sclk_d;
    s_state_d = s_state_q;
    case (s_state_q)
      S_IDLE:   if (ss_fall) s_state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (ss_n) s_state_d = S_IDLE;
        else if (sclk_rise && bit_cnt == 3'd7) s_state_d = S_DONE;
      end
      S_DONE:   s_state_d = S_IDLE;
      default:  s_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s_state_q     <= S_IDLE;
      sclk_d        <= 1'b0;
      ss_n_d        <= 1'b1;
      bit_cnt       <= '0;
      s_tx_shift    <= '0;
      s_rx_shift    <= '0;
      miso_bit      <= 1'b0;
      slave_rx_data <= '0;
      data_received <= 1'b0;
    end else begin
      s_state_q     <= s_state_d;
      sclk_d        <= sclk;
      ss_n_d        <= ss_n;
      data_received <= 1'b0;
      case (s_state_q)
        S_IDLE: begin
          if (ss_fall) begin
            s_tx_shift <= slave_tx_data;
            s_rx_shift <= '0;
            miso_bit   <= out_bit(slave_tx_data);
            bit_cnt    <= '0;
          end
        end
        S_ACTIVE: begin
          if (ss_n) begin
            miso_bit <= 1'b0;
          end else if (sclk_rise) begin
            s_rx_shift <= shift_in(s_rx_shift, mosi);
            bit_cnt    <= bit_cnt + 3'd1;
          end else if (sclk_fall) begin
            s_tx_shift <= shift_out(s_tx_shift);
            miso_bit   <= out_bit(shift_out(s_tx_shift));
          end
        end
        S_DONE: begin
          slave_rx_data <= s_rx_shift;
          data_received <= 1'b1;
          miso_bit      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_slave.sv
// Scoreboard bench for spi_master_slave: expected bytes and completion cycles are queued at
// each start and compared when the completion pulses appear; bus bits are checked per sclk rise.
module tb_spi_master_slave;

  localparam int DIV = 3;
  localparam int LAT = 17 * DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       start_transfer;
  logic       transfer_done;
  logic [7:0] rx_data;
  logic [7:0] slave_tx_data;
  logic [7:0] slave_rx_data;
  logic       data_received;
  logic       sclk, ss_n, mosi, miso;

  spi_master_slave #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .start_transfer(start_transfer),
    .transfer_done(transfer_done), .rx_data(rx_data), .slave_tx_data(slave_tx_data),
    .slave_rx_data(slave_rx_data), .data_received(data_received),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    int         done_cyc;
  } m_exp_t;

  m_exp_t     m_q[$];
  logic [7:0] s_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         done_total = 0;
  logic       dr_flag = 1'b0;
  logic       sclk_prev = 1'b0;
  int         bit_idx = 0;
  logic [7:0] cur_tx = '0;
  logic [7:0] cur_stx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic bit_of(input logic [7:0] b, input int k);
`ifdef SPI_LSB_FIRST_EN
    return b[k];
`else
    return b[7 - k];
`endif
  endfunction

  // Monitor: completion pulses against the scoreboard, bus bits at each sclk rise.
  always @(negedge clk) begin
    if (data_received) begin
      if (s_q.size() == 0) check("spurious_data_received", 1, 0);
      else check("slave_rx_data", {24'd0, slave_rx_data}, {24'd0, s_q.pop_front()});
      dr_flag = 1'b1;
    end
    if (transfer_done) begin
      done_total++;
      if (m_q.size() == 0) check("spurious_transfer_done", 1, 0);
      else begin
        m_exp_t e;
        e = m_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
        check("done_latency", cyc, e.done_cyc);
        check("dr_before_done", {31'd0, dr_flag}, 1);
      end
      dr_flag = 1'b0;
    end
    if (sclk && !sclk_prev && !ss_n && bit_idx < 8) begin
      check("mosi_bit", {31'd0, mosi}, {31'd0, bit_of(cur_tx, bit_idx)});
      check("miso_bit", {31'd0, miso}, {31'd0, bit_of(cur_stx, bit_idx)});
      bit_idx++;
    end
    sclk_prev = sclk;
  end

  // Called at a negedge; the next posedge is E0.
  task automatic start_frame(input logic [7:0] t, input logic [7:0] s);
    m_exp_t e;
    tx_data        = t;
    slave_tx_data  = s;
    start_transfer = 1'b1;
    cur_tx  = t;
    cur_stx = s;
    bit_idx = 0;
    e.rx       = s;
    e.done_cyc = cyc + 1 + LAT;
    m_q.push_back(e);
    s_q.push_back(t);
    @(negedge clk);
    start_transfer = 1'b0;
    tx_data        = 8'h00;
    check("mosi_first_bit", {31'd0, mosi}, {31'd0, bit_of(t, 0)});
    check("ss_n_low", {31'd0, ss_n}, 0);
  endtask

  // Returns at the negedge where transfer_done is high.
  task automatic wait_done();
    int n = 0;
    while (!transfer_done && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (!transfer_done) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_sclk", {31'd0, sclk}, 0);
    check("rst_ss_n", {31'd0, ss_n}, 1);
    check("rst_mosi", {31'd0, mosi}, 0);
    check("rst_miso", {31'd0, miso}, 0);
    check("rst_rx_data", {24'd0, rx_data}, 0);
    check("rst_slave_rx_data", {24'd0, slave_rx_data}, 0);
    check("rst_transfer_done", {31'd0, transfer_done}, 0);
    check("rst_data_received", {31'd0, data_received}, 0);
  endtask

  initial begin
    int rises;
    int n;
    int done_before;
    logic prev;

    rst_n = 1'b1;
    tx_data = '0;
    slave_tx_data = '0;
    start_transfer = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b0;
    @(negedge clk);

    // Basic frame and latency.
    start_frame(8'h5A, 8'hAA);
    wait_done();

    // Idle gap, then a second pattern.
    repeat (10) @(negedge clk);
    start_frame(8'hC3, 8'hB5);
    wait_done();

    // Zero reply; bus must be released afterwards.
    @(negedge clk);
    start_frame(8'h12, 8'h00);
    wait_done();
    check("ss_n_after", {31'd0, ss_n}, 1);
    check("miso_after", {31'd0, miso}, 0);
    check("sclk_after", {31'd0, sclk}, 0);

    // Start request mid-frame must be ignored.
    @(negedge clk);
    done_before = done_total;
    start_frame(8'h66, 8'h99);
    repeat (20) @(negedge clk);
    tx_data = 8'hFF;
    start_transfer = 1'b1;
    @(negedge clk);
    start_transfer = 1'b0;
    wait_done();
    repeat (2 * LAT) @(negedge clk);
    check("single_done", done_total - done_before, 1);

    // Back-to-back: next start sampled on the edge right after transfer_done.
    start_frame(8'hA5, 8'h5A);
    wait_done();
    start_frame(8'h0F, 8'hF0);
    wait_done();

    // Reset after four sclk rises of a 0x5A frame.
    @(negedge clk);
    start_frame(8'h5A, 8'h33);
    rises = 0;
    n = 0;
    prev = sclk;
    while (rises < 4 && n < 4 * LAT) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      n++;
    end
    if (rises < 4) check("sclk_rise_timeout", 0, 1);
    m_q.delete();
    s_q.delete();
    dr_flag = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b0;
    done_before = done_total;
    repeat (2 * LAT) @(negedge clk);
    check("no_pulse_after_reset", done_total - done_before, 0);
    start_frame(8'h3C, 8'h81);
    wait_done();

`ifdef SPI_LSB_FIRST_EN
    @(negedge clk);
    start_frame(8'h01, 8'h80);
    wait_done();
`endif

    repeat (20) @(negedge clk);
    check("queues_drained", m_q.size() + s_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
